// File: rtl/chunked_seq_adder_pkg.sv
// Shared constants for the chunked sequential adder.
//   StIdle / StRun   : FSM state encodings (1-bit, legacy-compatible constants)
//   ModeAdd / ModeSub: values of the sub input
//   cnt_width()      : chunk counter width, never less than 1
package chunked_seq_adder_pkg;

  localparam logic StIdle  = 1'b0;
  localparam logic StRun   = 1'b1;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// Handshake and data bundle of the chunked sequential adder.
//   start/sub/a/b/cin : request side, driven by the master
//   busy/done         : operation status, driven by the slave
//   s/cout/ovf        : result, valid when done pulses, held until the next completion
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/chunked_seq_adder_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice (the adder_chunk of the datapath).
//   a, b : chunk operands
//   cin  : carry into bit 0
//   sum  : chunk sum
//   cout : carry out of the top bit
//   cmsb : carry into the top bit (needed for signed overflow on the last chunk)
module chunked_seq_adder_adder_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK - 1];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// keeping the inter-chunk carry in a register. WIDTH must be a multiple of CHUNK.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts an operation without a done pulse
//   bus   : slave side of chunked_seq_adder_if (start/sub/a/b/cin in; busy/done/s/cout/ovf out)
// Result appears with done exactly WIDTH/CHUNK cycles after the accepting edge.
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  chunked_seq_adder_if.slave  bus
);

  localparam int unsigned NChunk  = WIDTH / CHUNK;
  localparam int unsigned CntW    = cnt_width(NChunk);
  localparam logic [CntW-1:0] LastCnt = CntW'(NChunk - 1);

  logic             state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;   // already inverted for subtraction
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout, chunk_cmsb;

  assign a_chunk = a_q[cnt_q * CHUNK +: CHUNK];
  assign b_chunk = b_q[cnt_q * CHUNK +: CHUNK];

  chunked_seq_adder_adder_chunk #(
    .CHUNK (CHUNK)
  ) u_adder_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (state_q == StIdle) begin
      // Idle also covers the done cycle, so back-to-back starts are accepted here.
      if (bus.start) begin
        a_d     = bus.a;
        b_d     = (bus.sub == ModeSub) ? ~bus.b : bus.b;
        carry_d = (bus.sub == ModeAdd) ? bus.cin : 1'b1;
        cnt_d   = '0;
        state_d = StRun;
      end
    end else begin
      res_d[cnt_q * CHUNK +: CHUNK] = chunk_sum;
      carry_d = chunk_cout;
      if (cnt_q == LastCnt) begin
        // Publish only the complete word so s never shows partial sums.
        s_d     = res_d;
        cout_d  = chunk_cout;
        ovf_d   = chunk_cmsb ^ chunk_cout;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder: a 32/8 instance (4-cycle) and an 8/8 instance (1-cycle).
module tb_chunked_seq_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(32)) bus32 ();
  chunked_seq_adder_if #(.WIDTH(8))  bus8 ();

  chunked_seq_adder #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  chunked_seq_adder #(
    .WIDTH (8),
    .CHUNK (8)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // Present a request, return #1 after the accepting edge with start dropped.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub);
    bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  // Cycles until done, -1 if the budget expires.
  task automatic wait_done32(output int lat);
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (bus32.done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (bus8.done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({bus32.busy, bus32.done, bus32.s, bus32.cout, bus32.ovf} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset32: got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               bus32.busy, bus32.done, bus32.s, bus32.cout, bus32.ovf);
    end
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset8: got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf);
    end
  endtask

  task automatic test_latency;
    issue32(32'd0, 32'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus32.busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_after_accept: got %b want 1", bus32.busy);
    end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (i < 4) begin
        if ({bus32.busy, bus32.done} !== 2'b10) begin
          n_bad++;
          $display("FAIL lat_cycle%0d: got busy,done=%b%b want 10", i, bus32.busy, bus32.done);
        end
      end else begin
        if ({bus32.busy, bus32.done, bus32.s, bus32.cout, bus32.ovf} !== {2'b01, 32'd0, 2'b00})
        begin
          n_bad++;
          $display("FAIL zero_add: got busy=%b done=%b s=%h cout=%b ovf=%b want 0 1 0 0 0",
                   bus32.busy, bus32.done, bus32.s, bus32.cout, bus32.ovf);
        end
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus32.done !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse_width: got %b want 0", bus32.done);
    end
  endtask

  task automatic test_carry_ripple;
    int lat;
    issue32(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_done32(lat);
    n_cmp++;
    if (lat !== 4 || {bus32.s, bus32.cout, bus32.ovf} !== {32'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ripple: got lat=%0d s=%h cout=%b ovf=%b want 4 00000000 1 0",
               lat, bus32.s, bus32.cout, bus32.ovf);
    end
  endtask

  task automatic test_overflow_sub;
    int lat;
    issue32(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_done32(lat);
    n_cmp++;
    if (lat !== 4 || {bus32.s, bus32.cout, bus32.ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL signed_ovf: got lat=%0d s=%h cout=%b ovf=%b want 4 80000000 0 1",
               lat, bus32.s, bus32.cout, bus32.ovf);
    end
    // cin is ignored for subtraction
    issue32(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done32(lat);
    n_cmp++;
    if (lat !== 4 || {bus32.s, bus32.cout, bus32.ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_borrow: got lat=%0d s=%h cout=%b ovf=%b want 4 fffffffe 0 0",
               lat, bus32.s, bus32.cout, bus32.ovf);
    end
    issue32(32'd9, 32'd4, 1'b0, 1'b1);
    wait_done32(lat);
    n_cmp++;
    if ({bus32.s, bus32.cout, bus32.ovf} !== {32'd5, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_noborrow: got s=%h cout=%b ovf=%b want 00000005 1 0",
               bus32.s, bus32.cout, bus32.ovf);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue32(32'd100, 32'd200, 1'b0, 1'b0);
    @(posedge clk); #1;
    // start while busy with other operands must be ignored
    bus32.a = 32'd1; bus32.b = 32'd1; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    wait_done32(lat);
    n_cmp++;
    if (lat !== 2 || bus32.s !== 32'h0000_012C) begin
      n_bad++;
      $display("FAIL start_while_busy: got lat=%0d s=%h want 2 0000012c", lat, bus32.s);
    end
    // start in the done cycle
    issue32(32'd3, 32'd4, 1'b0, 1'b0);
    n_cmp++;
    if ({bus32.busy, bus32.done, bus32.s} !== {2'b10, 32'h0000_012C}) begin
      n_bad++;
      $display("FAIL b2b_accept: got busy=%b done=%b s=%h want 1 0 0000012c",
               bus32.busy, bus32.done, bus32.s);
    end
    wait_done32(lat);
    n_cmp++;
    if (lat !== 4 || bus32.s !== 32'd7) begin
      n_bad++;
      $display("FAIL b2b_result: got lat=%0d s=%h want 4 00000007", lat, bus32.s);
    end
  endtask

  task automatic test_abort;
    int lat;
    issue32(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus32.busy, bus32.done, bus32.s, bus32.cout, bus32.ovf} !== 35'd0) begin
      n_bad++;
      $display("FAIL abort_clear: got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               bus32.busy, bus32.done, bus32.s, bus32.cout, bus32.ovf);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus32.done !== 1'b0) begin
        n_bad++; $display("FAIL abort_no_done: got %b want 0", bus32.done);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue32(32'd10, 32'd20, 1'b0, 1'b0);
    wait_done32(lat);
    n_cmp++;
    if (lat !== 4 || {bus32.s, bus32.cout, bus32.ovf} !== {32'd30, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL after_abort: got lat=%0d s=%h cout=%b ovf=%b want 4 0000001e 0 0",
               lat, bus32.s, bus32.cout, bus32.ovf);
    end
  endtask

  task automatic test_single_chunk;
    int lat;
    issue8(8'hAA, 8'h55, 1'b1, 1'b0);
    wait_done8(lat);
    n_cmp++;
    if (lat !== 1 || {bus8.s, bus8.cout, bus8.ovf} !== {8'h00, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL w8_aa55: got lat=%0d s=%h cout=%b ovf=%b want 1 00 1 0",
               lat, bus8.s, bus8.cout, bus8.ovf);
    end
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done8(lat);
    n_cmp++;
    if (lat !== 1 || {bus8.s, bus8.cout, bus8.ovf} !== {8'hFF, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL w8_ffff: got lat=%0d s=%h cout=%b ovf=%b want 1 ff 1 0",
               lat, bus8.s, bus8.cout, bus8.ovf);
    end
    issue8(8'h40, 8'h40, 1'b0, 1'b0);
    wait_done8(lat);
    n_cmp++;
    if ({bus8.s, bus8.cout, bus8.ovf} !== {8'h80, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL w8_ovf: got s=%h cout=%b ovf=%b want 80 0 1",
               bus8.s, bus8.cout, bus8.ovf);
    end
  endtask

  initial begin
    bus32.start = 1'b0; bus32.sub = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
    bus8.start  = 1'b0; bus8.sub  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_latency();
    test_carry_ripple();
    test_overflow_sub();
    test_back_to_back();
    test_abort();
    test_single_chunk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
